dbus_mem_responder: RTL and testbench

Behavioural data-memory responder on the D-bus: accepts `dbus_req_t` transactions from a core (or from the core-side bus adapters) and answers with `dbus_resp_t` after a fixed or randomised latency. It sits at the slave end of the D-bus, taking the place of the SoC memory in unit and core-level benches. It also exercises the initiator's `addr_ok`/`data_ok` handling under multi-cycle latency, which a zero-latency SRAM path never does.

---
 rtl/dbus_mem_responder_pkg.sv | 35 +++
 rtl/dbus_mem_responder_lfsr16.sv | 17 +
 rtl/dbus_mem_responder.sv | 112 +++++++++++
 tb/tb_dbus_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_mem_responder_pkg.sv
// Shared D-bus package: request/response types, strobe/size typedefs,
// plus the memory responder's FSM state enum and LFSR seed.
package dbus_mem_responder_pkg;

    typedef logic [3:0] strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        strobe_t     strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    localparam logic [15:0] DBUS_RESP_LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dbus_resp_state_t;

endpackage

// File: rtl/dbus_mem_responder_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1,
// synchronously reset to SEED.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr
);

    // Shift right every cycle, folding the output bit back into the taps.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= SEED;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

endmodule

// File: rtl/dbus_mem_responder.sv
// D-bus data-memory responder: one outstanding transaction, answered
// LATENCY cycles after acceptance, read-before-write on the same word.
// Optional feature macro: DBUS_RESP_RANDOM_DELAY_EN adds 0..7 extra wait
// cycles per transaction drawn from an LFSR.
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [4:0] LOAD_BASE = 5'(LATENCY - 1);

    // Not cleared by reset; starts at zero.
    logic [31:0] mem [DEPTH] = '{default: '0};

    dbus_resp_state_t        state_q;
    logic [4:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [3:0]              strobe_q;
    logic [31:0]             wdata_q;
    logic [4:0]              extra;
    logic [4:0]              load;
    logic                    addr_ok;
    logic                    data_ok;
    logic                    accept;

`ifdef DBUS_RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    lfsr16 #(.SEED(DBUS_RESP_LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr_q)
    );

    assign extra       = {2'b00, lfsr_q[2:0]};
    assign unused_lfsr = ^lfsr_q[15:3];
`else
    assign extra = '0;
`endif

    // Size and the address bits outside the word index play no part.
    logic unused_req;
    assign unused_req = ^{dreq.size, dreq.addr[31:DEPTH_LOG2+2], dreq.addr[1:0]};

    assign addr_ok = (state_q == IDLE) && !reset;
    assign data_ok = (state_q == RESP) && !reset;
    assign accept  = addr_ok && dreq.valid;
    assign load    = LOAD_BASE + extra;

    // Control FSM: accept, count down the latency, respond for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dreq.valid) begin
                        cnt_q   <= load;
                        state_q <= (load == 5'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 5'd1) begin
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Latch the accepted request; later dreq changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q    <= dreq.addr[DEPTH_LOG2+1:2];
            strobe_q <= dreq.strobe;
            wdata_q  <= dreq.data;
        end
    end

    // Commit the byte-masked write on the edge that closes RESP.
    always_ff @(posedge clk) begin
        if (data_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    // Response: read data only during RESP, zero otherwise.
    always_comb begin
        dresp         = '0;
        dresp.addr_ok = addr_ok;
        dresp.data_ok = data_ok;
        dresp.data    = data_ok ? mem[idx_q] : 32'h0;
    end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Self-checking bench for dbus_mem_responder with a word-array reference model.
module tb_dbus_mem_responder;
    import dbus_mem_responder_pkg::*;

    localparam int DEPTH_LOG2 = 10;
    localparam int LATENCY    = 2;
`ifdef DBUS_RESP_RANDOM_DELAY_EN
    localparam int EXTRA_MAX = 7;
`else
    localparam int EXTRA_MAX = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq;
    dbus_resp_t dresp;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [1 << DEPTH_LOG2];

    dbus_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .dreq  (dreq),
        .dresp (dresp)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'(a[DEPTH_LOG2+1:2]);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic bit lat_ok(input int lat);
        return lat >= LATENCY && lat <= LATENCY + EXTRA_MAX;
    endfunction

    // Drives one transaction; lat=-1 on timeout. ao_bad flags addr_ok seen while outstanding.
    task automatic do_txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output int wt, output bit ao_bad);
        bit got;
        rd = '0; lat = -1; wt = 0; ao_bad = 0; got = 0;
        dreq.valid = 1'b1; dreq.addr = a; dreq.strobe = s; dreq.data = d; dreq.size = MSIZE4;
        while (!got && wt <= 50) begin
            @(negedge clk);
            if (dresp.addr_ok) got = 1;
            else wt++;
        end
        @(posedge clk); #1;
        dreq.valid  = 1'b0;
        dreq.addr   = $urandom;
        dreq.data   = $urandom;
        dreq.strobe = 4'($urandom);
        if (!got) return;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dresp.addr_ok) ao_bad = 1;
            if (dresp.data_ok) begin
                lat = c;
                rd  = dresp.data;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat, wt; bit ao;
        reset = 1'b1;
        dreq = '0; dreq.valid = 1'b1; dreq.size = MSIZE4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (dresp.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got=%b exp=0", dresp.addr_ok); end
            checks++;
            if (dresp.data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got=%b exp=0", dresp.data_ok); end
            checks++;
            if (dresp.data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", dresp.data); end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        do_txn(32'h0, 4'h0, 32'h0, rd, lat, wt, ao);
        checks++;
        if (wt !== 0) begin errors++; $display("FAIL reset_first_accept wait=%0d exp=0", wt); end
        checks++;
        if (!lat_ok(lat) || rd !== 32'h0) begin errors++; $display("FAIL reset_first_read lat=%0d data=%h exp_data=0", lat, rd); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; int lat, wt; bit ao;
        do_txn(32'h0000_0010, 4'hF, 32'hDEAD_BEEF, rd, lat, wt, ao);
        model_write(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        checks++;
        if (!lat_ok(lat)) begin errors++; $display("FAIL wr_latency got=%0d exp=%0d..%0d", lat, LATENCY, LATENCY + EXTRA_MAX); end
        checks++;
        if (ao) begin errors++; $display("FAIL wr_addr_ok_while_busy got=1 exp=0"); end
        do_txn(32'h0000_0010, 4'h0, 32'h0, rd, lat, wt, ao);
        checks++;
        if (wt !== 0) begin errors++; $display("FAIL rd_back_to_back wait=%0d exp=0", wt); end
        checks++;
        if (!lat_ok(lat) || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data lat=%0d got=%h exp=deadbeef", lat, rd); end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] rd; int lat, wt; bit ao;
        do_txn(32'h0000_0020, 4'hF, 32'h1122_3344, rd, lat, wt, ao);
        model_write(32'h0000_0020, 4'hF, 32'h1122_3344);
        do_txn(32'h0000_0020, 4'b0101, 32'hAABB_CCDD, rd, lat, wt, ao);
        checks++;
        if (rd !== 32'h1122_3344) begin errors++; $display("FAIL partial_read_before_write got=%h exp=11223344", rd); end
        model_write(32'h0000_0020, 4'b0101, 32'hAABB_CCDD);
        do_txn(32'h0000_0020, 4'h0, 32'h0, rd, lat, wt, ao);
        checks++;
        if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL partial_strobe got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_alias();
        logic [31:0] rd; int lat, wt; bit ao;
        do_txn(32'h0000_1004, 4'hF, 32'h1234_5678, rd, lat, wt, ao);
        model_write(32'h0000_1004, 4'hF, 32'h1234_5678);
        do_txn(32'h0000_0004, 4'h0, 32'h0, rd, lat, wt, ao);
        checks++;
        if (rd !== 32'h1234_5678) begin errors++; $display("FAIL alias got=%h exp=12345678", rd); end
    endtask

    task automatic test_holdoff();
        logic [31:0] q_exp[$];
        logic [31:0] exp;
        int acc, rsp, last_acc;
        acc = 0; rsp = 0; last_acc = 0;
        dreq.valid = 1'b1; dreq.strobe = 4'h0; dreq.size = MSIZE4;
        dreq.addr = 32'($urandom_range(0, 15)) << 2;
        for (int cyc = 0; cyc < 300 && rsp < 8; cyc++) begin
            @(negedge clk);
            if (dresp.addr_ok && dresp.data_ok) begin
                checks++; errors++;
                $display("FAIL holdoff_overlap addr_ok=1 data_ok=1 exp=not both");
            end
            if (dresp.data_ok) begin
                checks++;
                exp = (q_exp.size() > 0) ? q_exp.pop_front() : 32'hX;
                if (dresp.data !== exp || !lat_ok(cyc - last_acc)) begin
                    errors++;
                    $display("FAIL holdoff_resp data=%h exp=%h lat=%0d", dresp.data, exp, cyc - last_acc);
                end
                rsp++;
            end
            if (dresp.addr_ok) begin
                if (acc > 0) begin
                    checks++;
                    if ((cyc - last_acc) < LATENCY + 1 || (cyc - last_acc) > LATENCY + 1 + EXTRA_MAX) begin
                        errors++;
                        $display("FAIL holdoff_gap got=%0d exp=%0d..%0d", cyc - last_acc, LATENCY + 1, LATENCY + 1 + EXTRA_MAX);
                    end
                end
                q_exp.push_back(model[widx(dreq.addr)]);
                last_acc = cyc;
                acc++;
            end
            @(posedge clk); #1;
            dreq.addr = 32'($urandom_range(0, 15)) << 2;
            if (acc == 8) dreq.valid = 1'b0;
        end
        dreq.valid = 1'b0;
        checks++;
        if (acc != 8 || rsp != 8) begin errors++; $display("FAIL holdoff_count acc=%0d rsp=%0d exp=8/8", acc, rsp); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat, wt, seen; bit ao, got;
        got = 0; seen = 0;
        dreq.valid = 1'b1; dreq.addr = 32'h0000_0800; dreq.strobe = 4'hF;
        dreq.data = 32'hFFFF_FFFF; dreq.size = MSIZE4;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (dresp.addr_ok) got = 1;
        end
        @(posedge clk); #1;
        dreq.valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (!got || dresp.addr_ok !== 1'b0 || dresp.data_ok !== 1'b0 || dresp.data !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs accepted=%0d addr_ok=%b data_ok=%b data=%h exp=0/0/0", got, dresp.addr_ok, dresp.data_ok, dresp.data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dresp.addr_ok !== 1'b1) begin errors++; $display("FAIL midreset_addr_ok got=%b exp=1", dresp.addr_ok); end
        if (dresp.data_ok) seen++;
        for (int i = 0; i < LATENCY + EXTRA_MAX + 3; i++) begin
            @(negedge clk);
            if (dresp.data_ok) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_no_data_ok got=%0d exp=0", seen); end
        @(posedge clk); #1;
        do_txn(32'h0000_0800, 4'h0, 32'h0, rd, lat, wt, ao);
        checks++;
        if (!lat_ok(lat) || rd !== model[widx(32'h0000_0800)]) begin
            errors++;
            $display("FAIL midreset_read lat=%0d got=%h exp=%h", lat, rd, model[widx(32'h0000_0800)]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp; logic [3:0] s; int lat, wt; bit ao;
        for (int n = 0; n < 256; n++) begin
            a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
            s = 4'($urandom);
            d = $urandom;
            exp = model[widx(a)];
            do_txn(a, s, d, rd, lat, wt, ao);
            model_write(a, s, d);
            checks++;
            if (rd !== exp || !lat_ok(lat) || ao) begin
                errors++;
                $display("FAIL random[%0d] addr=%h data=%h exp=%h lat=%0d addr_ok_busy=%0d", n, a, rd, exp, lat, ao);
            end
        end
    endtask

    initial begin
        foreach (model[i]) model[i] = 32'h0;
        test_reset();
        test_write_read();
        test_partial_strobe();
        test_alias();
        test_holdoff();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
